// File: rtl/conv2_window_gen_pkg.sv
// rtl/conv2_window_gen_pkg.sv - shared constants, types and tap mapping for the conv2 window generator
package conv2_pkg;

  localparam int DW        = 12;
  localparam int K         = 5;
  localparam int WIDTH     = 12;
  localparam int HEIGHT    = 12;
  localparam int CHAIN_LEN = (K-1)*WIDTH + K;

  // Raster position counters; 4 bits covers 0..11 in both directions
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] COL_LAST      = CNT_W'(WIDTH-1);
  localparam logic [CNT_W-1:0] ROW_LAST      = CNT_W'(HEIGHT-1);
  localparam logic [CNT_W-1:0] EMIT_FIRST    = CNT_W'(K-1);
  localparam logic [CNT_W-1:0] FILL_LAST_ROW = CNT_W'(K-2);

  typedef logic signed [DW-1:0] pix_t;
  typedef pix_t [K*K-1:0] win_t;

  typedef enum logic {S_FILL, S_EMIT} state_t;

  // How many beats back from the current pixel window element i lives (0 = current pixel)
  function automatic int tap_offset(input int i);
    return (K-1-(i/K))*WIDTH + (K-1-(i%K));
  endfunction

endpackage

// File: rtl/conv2_window_gen_line_shift.sv
// rtl/conv2_window_gen_line_shift.sv - one-channel raster shift chain with K*K window taps
module conv2_line_shift
  import conv2_pkg::*;
(
  input  logic                clk,
  input  logic                valid_in,
  input  logic [DW-1:0]       data_in,
  output logic [K*K*DW-1:0]   win
);

  // Entry 0 of the full chain is the incoming pixel itself, so a window is
  // complete combinationally on the beat that finishes it.
  logic [CHAIN_LEN-2:0][DW-1:0] r_chain;
  logic [CHAIN_LEN-1:0][DW-1:0] w_full;

  assign w_full = {r_chain, data_in};

  // Advance the chain by one pixel per accepted beat; data path needs no reset
  always_ff @(posedge clk) begin
    if (valid_in) begin
      r_chain <= w_full[CHAIN_LEN-2:0];
    end
  end

  for (genvar i = 0; i < K*K; i++) begin : g_tap
    localparam int OFF = tap_offset(i);
    assign win[i*DW +: DW] = w_full[OFF];
  end

endmodule

// File: rtl/conv2_window_gen.sv
// rtl/conv2_window_gen.sv - 5x5x3 sliding-window generator; optional CONV2_WIN_POS_EN adds out_row/out_col
module conv2_window_gen
  import conv2_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid_in,
  input  logic [DW-1:0]       data_in1,
  input  logic [DW-1:0]       data_in2,
  input  logic [DW-1:0]       data_in3,
  output logic [K*K*DW-1:0]   win_ch1,
  output logic [K*K*DW-1:0]   win_ch2,
  output logic [K*K*DW-1:0]   win_ch3,
  output logic                valid_out_buf,
  output logic                frame_done
`ifdef CONV2_WIN_POS_EN
  ,
  output logic [2:0]          out_row,
  output logic [2:0]          out_col
`endif
);

  logic [K*K*DW-1:0] w_tap1;
  logic [K*K*DW-1:0] w_tap2;
  logic [K*K*DW-1:0] w_tap3;

  conv2_line_shift u_ch1 (.clk(clk), .valid_in(valid_in), .data_in(data_in1), .win(w_tap1));
  conv2_line_shift u_ch2 (.clk(clk), .valid_in(valid_in), .data_in(data_in2), .win(w_tap2));
  conv2_line_shift u_ch3 (.clk(clk), .valid_in(valid_in), .data_in(data_in3), .win(w_tap3));

  state_t           r_state;
  logic [CNT_W-1:0] r_col;
  logic [CNT_W-1:0] r_row;
  win_t             r_win1;
  win_t             r_win2;
  win_t             r_win3;
  logic             r_valid;
  logic             r_done;

  logic w_col_last;
  logic w_row_last;
  assign w_col_last = (r_col == COL_LAST);
  assign w_row_last = (r_row == ROW_LAST);

`ifdef CONV2_WIN_POS_EN
  logic [2:0] r_out_row;
  logic [2:0] r_out_col;

  // Output-map coordinate registered alongside the window strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_row <= '0;
      r_out_col <= '0;
    end else if (valid_in && r_state == S_EMIT && r_col >= EMIT_FIRST) begin
      r_out_row <= 3'(r_row - EMIT_FIRST);
      r_out_col <= 3'(r_col - EMIT_FIRST);
    end
  end

  assign out_row = r_out_row;
  assign out_col = r_out_col;
`endif

  // Raster counters, fill/emit FSM and registered window outputs; stalls when valid_in is low
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FILL;
      r_col   <= '0;
      r_row   <= '0;
      r_win1  <= '0;
      r_win2  <= '0;
      r_win3  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      if (valid_in) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + CNT_ONE;
        end else begin
          r_col <= r_col + CNT_ONE;
        end

        case (r_state)
          S_FILL: begin
            if (r_row == FILL_LAST_ROW && w_col_last) begin
              r_state <= S_EMIT;
            end
          end
          S_EMIT: begin
            if (r_col >= EMIT_FIRST) begin
              r_win1  <= w_tap1;
              r_win2  <= w_tap2;
              r_win3  <= w_tap3;
              r_valid <= 1'b1;
              r_done  <= w_row_last && w_col_last;
            end
            if (w_row_last && w_col_last) begin
              r_state <= S_FILL;
            end
          end
          default: r_state <= S_FILL;
        endcase
      end
    end
  end

  assign win_ch1       = r_win1;
  assign win_ch2       = r_win2;
  assign win_ch3       = r_win3;
  assign valid_out_buf = r_valid;
  assign frame_done    = r_done;

endmodule

// File: tb/tb_conv2_window_gen.sv
// tb/tb_conv2_window_gen.sv - scoreboard bench for conv2_window_gen
module tb_conv2_window_gen;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid_in;
  logic [11:0]  data_in1, data_in2, data_in3;
  logic [299:0] win_ch1, win_ch2, win_ch3;
  logic         valid_out_buf, frame_done;
`ifdef CONV2_WIN_POS_EN
  logic [2:0]   out_row, out_col;
`endif

  always #5 clk = ~clk;

  conv2_window_gen dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
    .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
    .win_ch1(win_ch1), .win_ch2(win_ch2), .win_ch3(win_ch3),
    .valid_out_buf(valid_out_buf), .frame_done(frame_done)
`ifdef CONV2_WIN_POS_EN
    , .out_row(out_row), .out_col(out_col)
`endif
  );

  typedef struct {
    logic [299:0] w1;
    logic [299:0] w2;
    logic [299:0] w3;
    logic         done;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_pop;
  int          checks = 0;
  int          errors = 0;
  int          win_count = 0;
  int          done_count = 0;
  logic        exp_strobe_next = 1'b0;
  logic [11:0] last_done_w24 = '0;
  logic [11:0] img1 [12][12];
  logic [11:0] img2 [12][12];
  logic [11:0] img3 [12][12];
  int          m_row = 0;
  int          m_col = 0;

  function automatic logic [11:0] el(input logic [299:0] w, input int i);
    return w[i*12 +: 12];
  endfunction

  // Monitor: compare every cycle's strobe against the model, pop on each window
  always @(posedge clk) begin
    #2;
    checks++;
    assert (valid_out_buf === exp_strobe_next) else begin
      errors++; $error("FAIL strobe obs=%0b exp=%0b", valid_out_buf, exp_strobe_next);
    end
    if (valid_out_buf === 1'b1) begin
      win_count++;
      if (frame_done === 1'b1) begin
        done_count++;
        last_done_w24 = el(win_ch1, 24);
      end
      checks++;
      assert (sb.size() > 0) else begin
        errors++; $error("FAIL sb_empty obs=%0d exp=%0d", sb.size(), 1);
      end
      if (sb.size() > 0) begin
        e_pop = sb.pop_front();
        checks += 4;
        assert (win_ch1 === e_pop.w1) else begin
          errors++; $error("FAIL win_ch1 obs=%h exp=%h", win_ch1, e_pop.w1);
        end
        assert (win_ch2 === e_pop.w2) else begin
          errors++; $error("FAIL win_ch2 obs=%h exp=%h", win_ch2, e_pop.w2);
        end
        assert (win_ch3 === e_pop.w3) else begin
          errors++; $error("FAIL win_ch3 obs=%h exp=%h", win_ch3, e_pop.w3);
        end
        assert (frame_done === e_pop.done) else begin
          errors++; $error("FAIL frame_done obs=%0b exp=%0b", frame_done, e_pop.done);
        end
      end
    end else begin
      checks++;
      assert (frame_done === 1'b0) else begin
        errors++; $error("FAIL done_no_strobe obs=%0b exp=%0b", frame_done, 1'b0);
      end
    end
  end

  // One input cycle; the model records the pixel and predicts any window it completes
  task automatic beat(input logic v, input logic [11:0] a, input logic [11:0] b, input logic [11:0] c);
    exp_t e;
    @(negedge clk);
    valid_in = v; data_in1 = a; data_in2 = b; data_in3 = c;
    exp_strobe_next = 1'b0;
    if (v) begin
      img1[m_row][m_col] = a;
      img2[m_row][m_col] = b;
      img3[m_row][m_col] = c;
      if (m_row >= 4 && m_col >= 4) begin
        for (int r = 0; r < 5; r++) begin
          for (int q = 0; q < 5; q++) begin
            e.w1[(r*5+q)*12 +: 12] = img1[m_row-4+r][m_col-4+q];
            e.w2[(r*5+q)*12 +: 12] = img2[m_row-4+r][m_col-4+q];
            e.w3[(r*5+q)*12 +: 12] = img3[m_row-4+r][m_col-4+q];
          end
        end
        e.done = (m_row == 11 && m_col == 11);
        sb.push_back(e);
        exp_strobe_next = 1'b1;
      end
      if (m_col == 11) begin
        m_col = 0;
        m_row = (m_row == 11) ? 0 : m_row + 1;
      end else begin
        m_col = m_col + 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 12'($urandom), 12'($urandom), 12'($urandom));
  endtask

  // Drive up to nbeats pixels of a frame; ch1 = base + row*12 + col
  task automatic frame(input int base, input bit sat, input bit gaps, input int nbeats, input bit chk53);
    int n;
    logic [11:0] a, b, c;
    n = 0;
    for (int rr = 0; rr < 12; rr++) begin
      for (int cc = 0; cc < 12; cc++) begin
        if (n >= nbeats) return;
        if (gaps) begin
          while ($urandom_range(1, 0) == 1) idle(1);
        end
        a = 12'(base + rr*12 + cc);
        b = sat ? 12'h800 : 12'($urandom);
        c = sat ? 12'hFFF : 12'($urandom);
        beat(1'b1, a, b, c);
        n++;
        if (chk53 && n == 53) begin
          @(posedge clk); #1;
          checks += 5;
          assert (valid_out_buf === 1'b1) else begin
            errors++; $error("FAIL first_strobe obs=%0b exp=%0b", valid_out_buf, 1'b1);
          end
          assert (el(win_ch1, 0) === 12'(base)) else begin
            errors++; $error("FAIL w1_0 obs=%0d exp=%0d", el(win_ch1, 0), base);
          end
          assert (el(win_ch1, 4) === 12'(base + 4)) else begin
            errors++; $error("FAIL w1_4 obs=%0d exp=%0d", el(win_ch1, 4), base + 4);
          end
          assert (el(win_ch1, 20) === 12'(base + 48)) else begin
            errors++; $error("FAIL w1_20 obs=%0d exp=%0d", el(win_ch1, 20), base + 48);
          end
          assert (el(win_ch1, 24) === 12'(base + 52)) else begin
            errors++; $error("FAIL w1_24 obs=%0d exp=%0d", el(win_ch1, 24), base + 52);
          end
        end
      end
    end
  endtask

  task automatic check_counts(input int wins, input int dones);
    checks += 2;
    assert (win_count === wins) else begin
      errors++; $error("FAIL win_count obs=%0d exp=%0d", win_count, wins);
    end
    assert (done_count === dones) else begin
      errors++; $error("FAIL done_count obs=%0d exp=%0d", done_count, dones);
    end
  endtask

  task automatic check_zero(input string tag);
    checks += 5;
    assert (win_ch1 === '0) else begin errors++; $error("FAIL %s_w1 obs=%h exp=0", tag, win_ch1); end
    assert (win_ch2 === '0) else begin errors++; $error("FAIL %s_w2 obs=%h exp=0", tag, win_ch2); end
    assert (win_ch3 === '0) else begin errors++; $error("FAIL %s_w3 obs=%h exp=0", tag, win_ch3); end
    assert (valid_out_buf === 1'b0) else begin errors++; $error("FAIL %s_vob obs=%0b exp=0", tag, valid_out_buf); end
    assert (frame_done === 1'b0) else begin errors++; $error("FAIL %s_done obs=%0b exp=0", tag, frame_done); end
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b0;
    data_in1 = '0; data_in2 = '0; data_in3 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single continuous frame with first-window probes
    frame(0, 1'b0, 1'b0, 144, 1'b1);
    idle(2);
    check_counts(64, 1);
    checks++;
    assert (last_done_w24 === 12'd143) else begin
      errors++; $error("FAIL done_w24 obs=%0d exp=%0d", last_done_w24, 143);
    end

    // Same frame with random input gaps
    frame(0, 1'b0, 1'b1, 144, 1'b0);
    idle(2);
    check_counts(128, 2);

    // Saturated signed frame immediately followed by an offset frame
    frame(0, 1'b1, 1'b0, 144, 1'b0);
    frame(1000, 1'b0, 1'b0, 144, 1'b1);
    idle(2);
    check_counts(256, 4);

    // Mid-frame reset after 30 beats, then a fresh frame
    frame(0, 1'b0, 1'b0, 30, 1'b0);
    @(negedge clk);
    rst_n = 1'b0; valid_in = 1'b0;
    exp_strobe_next = 1'b0;
    m_row = 0; m_col = 0;
    @(posedge clk); #1;
    check_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    frame(500, 1'b0, 1'b0, 144, 1'b1);
    idle(2);
    check_counts(320, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
